// File: rtl/lmem_port_arbiter_if.sv
// Requester and memory-side signal bundle for the layer-memory port arbiter.
interface lmem_port_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic        lock0, lock1;
  logic [2:0]  sel0, sel1;
  logic [11:0] addr0, addr1;
  logic [19:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [19:0] rdata;
  logic [2:0]  csel;
  logic        crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_wr, cdata_rd;
  logic        sel_err;

  // arbiter side
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, sel0, sel1,
           addr0, addr1, wdata0, wdata1, cdata_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, csel, crd, cwr,
           caddr_rd, caddr_wr, cdata_wr, sel_err
  );

  // requesters plus memory side
  modport master (
    output req0, req1, we0, we1, lock0, lock1, sel0, sel1,
           addr0, addr1, wdata0, wdata1, cdata_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, csel, crd, cwr,
           caddr_rd, caddr_wr, cdata_wr, sel_err
  );
endinterface

// File: rtl/lmem_port_arbiter.sv
// Two-requester arbiter for the single layer-memory port.
// Round-robin on contention; a lock keeps ownership for a pooling window,
// bounded by LOCK_MAX grants while the other side waits.
//
// state     | meaning
// ARB_IDLE  | no owner, grant by request / round-robin pointer
// ARB_LOCK0 | requester 0 owns the port
// ARB_LOCK1 | requester 1 owns the port
module lmem_port_arbiter #(
  parameter int unsigned LOCK_MAX = 4,
  parameter logic [2:0]  SEL_L0   = 3'b001,
  parameter logic [2:0]  SEL_L1   = 3'b011
) (
  input logic               clk,
  input logic               reset,
  lmem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK0, ARB_LOCK1} arb_state_e;

  arb_state_e    state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic          crd_q, crd_d, cwr_q, cwr_d;
  logic [2:0]    csel_q, csel_d;
  logic [11:0]   caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
  logic [19:0]   cdata_wr_q, cdata_wr_d;
  logic          sel_err_q, sel_err_d;
  logic          rd_pend_q, rd_pend_d, rd_own_q, rd_own_d, rd_ill_q, rd_ill_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [19:0]   rdata_q, rdata_d;

  logic          gnt0_c, gnt1_c, gnt_any;
  logic          own1, own_req, own_lock, oth_req;
  logic          g_we, g_legal;
  logic [2:0]    g_sel;
  logic [11:0]   g_addr;
  logic [19:0]   g_wdata;

  // grant decision and next arbitration state
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    gnt0_c     = 1'b0;
    gnt1_c     = 1'b0;
    own1       = (state_q == ARB_LOCK1);
    own_req    = own1 ? bus.req1  : bus.req0;
    own_lock   = own1 ? bus.lock1 : bus.lock0;
    oth_req    = own1 ? bus.req0  : bus.req1;
    case (state_q)
      ARB_IDLE: begin
        if (bus.req0 && bus.req1) begin
          gnt0_c   = ~rr_ptr_q;
          gnt1_c   = rr_ptr_q;
          rr_ptr_d = ~rr_ptr_q;
        end else begin
          gnt0_c = bus.req0;
          gnt1_c = bus.req1;
        end
        if ((gnt0_c && bus.lock0) || (gnt1_c && bus.lock1)) begin
          state_d    = gnt1_c ? ARB_LOCK1 : ARB_LOCK0;
          lock_cnt_d = CW'(1);
        end
      end
      ARB_LOCK0, ARB_LOCK1: begin
        if (lock_cnt_q == CNT_MAX && oth_req) begin
          // starvation limit: drop the lock without granting this cycle
          state_d    = ARB_IDLE;
          rr_ptr_d   = ~own1;
          lock_cnt_d = '0;
        end else if (own_req) begin
          gnt0_c = ~own1;
          gnt1_c = own1;
          if (own_lock) begin
            if (lock_cnt_q != CNT_MAX) lock_cnt_d = lock_cnt_q + CW'(1);
          end else begin
            state_d    = ARB_IDLE;
            rr_ptr_d   = ~own1;
            lock_cnt_d = '0;
          end
        end else begin
          state_d    = ARB_IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // memory-side request for next cycle and read-return pipeline
  always_comb begin
    gnt_any    = gnt0_c | gnt1_c;
    g_we       = gnt1_c ? bus.we1    : bus.we0;
    g_sel      = gnt1_c ? bus.sel1   : bus.sel0;
    g_addr     = gnt1_c ? bus.addr1  : bus.addr0;
    g_wdata    = gnt1_c ? bus.wdata1 : bus.wdata0;
    g_legal    = (g_sel == SEL_L0) || (g_sel == SEL_L1);
    crd_d      = gnt_any & ~g_we & g_legal;
    cwr_d      = gnt_any & g_we & g_legal;
    csel_d     = (gnt_any && g_legal) ? g_sel : 3'b000;
    caddr_rd_d = crd_d ? g_addr : caddr_rd_q;
    caddr_wr_d = cwr_d ? g_addr : caddr_wr_q;
    cdata_wr_d = cwr_d ? g_wdata : '0;
    sel_err_d  = sel_err_q | (gnt_any & ~g_legal);
    // illegal-sel reads still return a beat so the requester never hangs
    rd_pend_d  = gnt_any & ~g_we;
    rd_own_d   = gnt1_c;
    rd_ill_d   = ~g_legal;
    rvalid0_d  = rd_pend_q & ~rd_own_q;
    rvalid1_d  = rd_pend_q & rd_own_q;
    rdata_d    = rd_pend_q ? (rd_ill_q ? 20'h0 : bus.cdata_rd) : rdata_q;
  end

  // all state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= 1'b0;
      lock_cnt_q <= '0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= 3'b000;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      sel_err_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_own_q   <= 1'b0;
      rd_ill_q   <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      csel_q     <= csel_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      sel_err_q  <= sel_err_d;
      rd_pend_q  <= rd_pend_d;
      rd_own_q   <= rd_own_d;
      rd_ill_q   <= rd_ill_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata_q    <= rdata_d;
    end
  end

  // grants are combinational but held off while reset is asserted
  assign bus.gnt0     = gnt0_c & reset;
  assign bus.gnt1     = gnt1_c & reset;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata    = rdata_q;
  assign bus.csel     = csel_q;
  assign bus.crd      = crd_q;
  assign bus.cwr      = cwr_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.cdata_wr = cdata_wr_q;
  assign bus.sel_err  = sel_err_q;
endmodule

// File: tb/tb_lmem_port_arbiter.sv
// Bench for lmem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_lmem_port_arbiter;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lmem_port_arbiter_if bus();

  lmem_port_arbiter #(.LOCK_MAX(LOCK_MAX), .SEL_L0(3'b001), .SEL_L1(3'b011)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic        req [2];
  logic        we  [2];
  logic        lock[2];
  logic [2:0]  sel [2];
  logic [11:0] addr[2];
  logic [19:0] wdata[2];
  logic        got [2];

  assign bus.req0 = req[0];   assign bus.req1 = req[1];
  assign bus.we0 = we[0];     assign bus.we1 = we[1];
  assign bus.lock0 = lock[0]; assign bus.lock1 = lock[1];
  assign bus.sel0 = sel[0];   assign bus.sel1 = sel[1];
  assign bus.addr0 = addr[0]; assign bus.addr1 = addr[1];
  assign bus.wdata0 = wdata[0]; assign bus.wdata1 = wdata[1];

  function automatic logic [19:0] mem_val(input logic [2:0] s, input logic [11:0] a);
    return {s[1], 7'h0, a} ^ 20'h0ABCD;
  endfunction

  // memory: data valid in the cycle crd is high, junk otherwise
  assign bus.cdata_rd = bus.crd ? mem_val(bus.csel, bus.caddr_rd) : 20'hFFFFF;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          owner;     // -1: nobody holds a lock
  int          held;      // consecutive locked grants to owner
  int          turn;      // winner on contention
  logic        e_crd, e_cwr, e_sel_err;
  logic [2:0]  e_csel;
  logic [11:0] e_caddr_rd, e_caddr_wr;
  logic [19:0] e_cdata_wr, e_rdata;
  logic        e_rv [2];
  int          p_who;     // read whose data is on the bus this cycle, -1 none
  logic        p_ill;
  logic [2:0]  p_sel;
  logic [11:0] p_addr;

  function automatic void model_reset();
    owner = -1; held = 0; turn = 0;
    e_crd = 0; e_cwr = 0; e_sel_err = 0; e_csel = 0;
    e_caddr_rd = 0; e_caddr_wr = 0; e_cdata_wr = 0; e_rdata = 0;
    e_rv[0] = 0; e_rv[1] = 0; p_who = -1; p_ill = 0; p_sel = 0; p_addr = 0;
  endfunction

  function automatic int model_pick();
    if (owner < 0) begin
      if (req[0] && req[1]) return turn;
      if (req[0]) return 0;
      if (req[1]) return 1;
      return -1;
    end
    if (held >= LOCK_MAX && req[1-owner]) return -1;
    return req[owner] ? owner : -1;
  endfunction

  function automatic void model_advance(input int g);
    logic legal;
    int o;
    if (owner < 0) begin
      if (g >= 0) begin
        if (req[0] && req[1]) turn = 1 - g;
        if (lock[g]) begin owner = g; held = 1; end
      end
    end else begin
      o = owner;
      if (held >= LOCK_MAX && req[1-o]) begin owner = -1; held = 0; turn = 1 - o; end
      else if (req[o]) begin
        if (lock[o]) held = (held < LOCK_MAX) ? held + 1 : held;
        else begin owner = -1; held = 0; turn = 1 - o; end
      end else begin owner = -1; held = 0; end
    end
    e_rv[0] = (p_who == 0);
    e_rv[1] = (p_who == 1);
    if (p_who >= 0) e_rdata = p_ill ? 20'h0 : mem_val(p_sel, p_addr);
    if (g >= 0) begin
      legal  = (sel[g] == 3'b001) || (sel[g] == 3'b011);
      e_crd  = !we[g] && legal;
      e_cwr  = we[g] && legal;
      e_csel = legal ? sel[g] : 3'b000;
      if (e_crd) e_caddr_rd = addr[g];
      if (e_cwr) e_caddr_wr = addr[g];
      e_cdata_wr = e_cwr ? wdata[g] : 20'h0;
      if (!legal) e_sel_err = 1'b1;
      p_who  = we[g] ? -1 : g;
      p_ill  = !legal; p_sel = sel[g]; p_addr = addr[g];
    end else begin
      e_crd = 0; e_cwr = 0; e_csel = 0; e_cdata_wr = 0; p_who = -1;
    end
  endfunction

  // compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    int g;
    if (!reset) begin
      chk("rst_gnt0", bus.gnt0, 0);     chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_rvalid0", bus.rvalid0, 0); chk("rst_rvalid1", bus.rvalid1, 0);
      chk("rst_crd", bus.crd, 0);       chk("rst_cwr", bus.cwr, 0);
      chk("rst_csel", bus.csel, 0);     chk("rst_sel_err", bus.sel_err, 0);
      chk("rst_caddr_rd", bus.caddr_rd, 0); chk("rst_caddr_wr", bus.caddr_wr, 0);
      chk("rst_cdata_wr", bus.cdata_wr, 0); chk("rst_rdata", bus.rdata, 0);
      model_reset();
      got[0] = 0; got[1] = 0;
    end else begin
      g = model_pick();
      chk("gnt0", bus.gnt0, g == 0);
      chk("gnt1", bus.gnt1, g == 1);
      chk("crd", bus.crd, e_crd);
      chk("cwr", bus.cwr, e_cwr);
      chk("csel", bus.csel, e_csel);
      chk("caddr_rd", bus.caddr_rd, e_caddr_rd);
      chk("caddr_wr", bus.caddr_wr, e_caddr_wr);
      chk("cdata_wr", bus.cdata_wr, e_cdata_wr);
      chk("rvalid0", bus.rvalid0, e_rv[0]);
      chk("rvalid1", bus.rvalid1, e_rv[1]);
      chk("rdata", bus.rdata, e_rdata);
      chk("sel_err", bus.sel_err, e_sel_err);
      model_advance(g);
      got[0] = (g == 0); got[1] = (g == 1);
    end
  end

  // ---------------- stimulus ----------------
  logic [11:0] burst_addr [4] = '{12'h000, 12'h001, 12'h040, 12'h041};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_reqs();
    for (int x = 0; x < 2; x++) begin
      req[x] = 0; we[x] = 0; lock[x] = 0; sel[x] = 0; addr[x] = 0; wdata[x] = 0;
    end
  endtask

  task automatic rq(input int x, input logic w, input logic l, input logic [2:0] s,
                    input logic [11:0] a, input logic [19:0] d);
    req[x] = 1; we[x] = w; lock[x] = l; sel[x] = s; addr[x] = a; wdata[x] = d;
  endtask

  task automatic do_reset();
    reset = 0; clear_reqs();
    step(); step();
    reset = 1;
  endtask

  initial begin
    reset = 1; clear_reqs(); got[0] = 0; got[1] = 0;
    #2 reset = 0;

    // single write
    do_reset();
    rq(0, 1, 0, 3'b001, 12'h041, 20'h01310);
    #1 chk("t1_gnt0", bus.gnt0, 1);
    step(); req[0] = 0;
    #1 chk("t1_cwr", bus.cwr, 1); chk("t1_csel", bus.csel, 3'b001);
    chk("t1_caddr_wr", bus.caddr_wr, 12'h041); chk("t1_cdata_wr", bus.cdata_wr, 20'h01310);
    step();
    #1 chk("t1_cwr_off", bus.cwr, 0); chk("t1_csel_off", bus.csel, 0);

    // read latency
    do_reset();
    rq(1, 0, 0, 3'b001, 12'h000, 20'h0);
    #1 chk("t2_gnt1", bus.gnt1, 1);
    step(); req[1] = 0;
    #1 chk("t2_crd", bus.crd, 1); chk("t2_caddr_rd", bus.caddr_rd, 12'h000);
    step();
    #1 chk("t2_rvalid1", bus.rvalid1, 1); chk("t2_rdata", bus.rdata, 20'h0ABCD);
    chk("t2_rvalid0", bus.rvalid0, 0);

    // round robin
    do_reset();
    rq(0, 0, 0, 3'b001, 12'h100, 20'h0);
    rq(1, 0, 0, 3'b011, 12'h200, 20'h0);
    for (int i = 0; i < 6; i++) begin
      #1 chk("t3_gnt0", bus.gnt0, (i % 2) == 0); chk("t3_gnt1", bus.gnt1, (i % 2) == 1);
      step();
    end
    clear_reqs();

    // lock burst
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rq(1, 0, i < 3, 3'b001, burst_addr[i], 20'h0);
      else req[1] = 0;
      if (i >= 1) rq(0, 0, 0, 3'b001, 12'h7FF, 20'h0);
      #1 chk("t4_gnt1", bus.gnt1, i < 4); chk("t4_gnt0", bus.gnt0, i == 4);
      if (i >= 1) chk("t4_caddr_rd", bus.caddr_rd, burst_addr[i-1]);
      step();
    end
    clear_reqs();

    // lock starvation limit
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rq(1, 0, 1, 3'b001, 12'((i > 3) ? 4 : i), 20'h0);
      if (i >= 1) rq(0, 1, 0, 3'b011, 12'h0AA, 20'h12345);
      #1 chk("t5_gnt1", bus.gnt1, i < 4); chk("t5_gnt0", bus.gnt0, i == 5);
      step();
    end
    clear_reqs();

    // illegal sel, then reset
    do_reset();
    rq(0, 0, 0, 3'b010, 12'h005, 20'h0);
    #1 chk("t6_gnt0", bus.gnt0, 1);
    step(); req[0] = 0;
    #1 chk("t6_crd", bus.crd, 0); chk("t6_csel", bus.csel, 0);
    step();
    #1 chk("t6_rvalid0", bus.rvalid0, 1); chk("t6_rdata", bus.rdata, 0);
    chk("t6_sel_err", bus.sel_err, 1);
    reset = 0;
    #1 chk("t6_rst_sel_err", bus.sel_err, 0); chk("t6_rst_crd", bus.crd, 0);
    chk("t6_rst_cwr", bus.cwr, 0);
    step(); reset = 1;
    rq(0, 0, 0, 3'b001, 12'h010, 20'h0);
    rq(1, 0, 0, 3'b001, 12'h020, 20'h0);
    #1 chk("t6_after_gnt0", bus.gnt0, 1); chk("t6_after_gnt1", bus.gnt1, 0);
    step(); clear_reqs();
    step();

    // randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 3000; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (!req[x] || got[x]) begin
          req[x]   = ($urandom_range(0, 3) != 0);
          we[x]    = 1'($urandom_range(0, 1));
          lock[x]  = ($urandom_range(0, 2) != 0);
          sel[x]   = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7))
                   : (($urandom_range(0, 1) == 0) ? 3'b001 : 3'b011);
          addr[x]  = 12'($urandom);
          wdata[x] = 20'($urandom);
        end
      end
      if ($urandom_range(0, 249) == 0) begin
        #2 reset = 0;
        @(posedge clk); #1 reset = 1;
      end
      step();
    end
    clear_reqs();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lmem_port_arbiter.md
Name: lmem_port_arbiter

Overview:
- Shares the single layer-memory port between two requesters:
  - Requester 0: the convolution writer, which writes layer 0.
  - Requester 1: the max-pool engine, which reads layer 0 and writes layer 1.
- Drives the memory-side csel/crd/cwr/caddr_rd/caddr_wr/cdata_wr and routes cdata_rd back to the requester that issued the read.
- Round-robin arbitration, plus a lock option so a 4-read pooling window completes without interleaving.

Parameters:
- LOCK_MAX, 4: maximum consecutive locked grants to one requester while the other requester is waiting.
- SEL_L0, 3'b001: csel code for layer-0 memory.
- SEL_L1, 3'b011: csel code for layer-1 memory.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req0, req1  in  1 each  access request; held with payload stable until the matching gnt.
- we0, we1  in  1 each  1 = write, 0 = read.
- lock0, lock1  in  1 each  keep ownership for the next access of the same requester.
- sel0, sel1  in  3 each  target memory code.
- addr0, addr1  in  12 each  word address.
- wdata0, wdata1  in  20 each  write data.
- gnt0, gnt1  out  1 each  combinational; access accepted at this rising edge.
- rvalid0, rvalid1  out  1 each  one-cycle pulse; rdata valid.
- rdata  out  20  registered read data, shared by both requesters.
- csel  out  3  memory select.
- crd  out  1  memory read strobe.
- cwr  out  1  memory write strobe.
- caddr_rd  out  12  memory read address.
- caddr_wr  out  12  memory write address.
- cdata_wr  out  20  memory write data.
- cdata_rd  in  20  memory read data, valid in the same cycle crd is high.
- sel_err  out  1  sticky flag: an illegal sel was granted.

Behaviour:
- Reset values (reset=0):
  - gnt*, rvalid*, crd, cwr, sel_err = 0.
  - csel = 3'b000; caddr_rd, caddr_wr, cdata_wr, rdata = 0.
  - FSM = ARB_IDLE; rr_ptr = 0; lock_cnt = 0.
- One access at most per cycle; a grant is an accepted transfer.
- FSM states and grant rules:
  - ARB_IDLE:
    - Only one req high: grant it.
    - Both high: grant rr_ptr's requester, then flip rr_ptr to the other.
    - Granted with lock=1: go to ARB_LOCKx, lock_cnt = 1.
  - ARB_LOCKx (x owns the port):
    - Only reqx is granted; the other requester waits.
    - Grant with lockx=1: lock_cnt+1.
    - Grant with lockx=0: return to ARB_IDLE and set rr_ptr to the other requester.
    - reqx=0 for one cycle: return to ARB_IDLE (lock abandoned).
    - lock_cnt == LOCK_MAX and the other req is high: the next cycle is forced to ARB_IDLE with rr_ptr = other. The pending grant is not given that cycle.
    - lock_cnt saturates at LOCK_MAX when the other requester is idle.
- Memory side: registered, driven in cycle N+1 after a grant at edge N.
  - Read: crd=1, caddr_rd=addr, csel=sel. Memory returns cdata_rd in N+1; captured into rdata at edge N+2; rvalidx=1 during N+2 (read latency 2).
  - Write: cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel.
  - No grant: crd=cwr=0, csel=3'b000, cdata_wr=0. Addresses hold their last value.
- Back-to-back grants produce consecutive strobes with no bubble. rvalid ownership is tracked per-cycle by a registered owner tag.
- Illegal sel (not SEL_L0 or SEL_L1):
  - The access is still granted (no deadlock).
  - No crd/cwr strobe is issued; csel=3'b000.
  - For a read, rvalid still pulses with rdata=0.
  - sel_err is set and holds until reset.
- Simultaneous req0/req1 with rr_ptr=0: gnt0 wins.
- Reset asserted mid-burst: everything returns to reset values immediately (asynchronous). In-flight rvalid is dropped.

Test Plan:
- Single write: req0=1, we0=1, sel0=001, addr0=12'h041, wdata0=20'h01310 → gnt0 in cycle 0; cycle 1 cwr=1, csel=001, caddr_wr=041, cdata_wr=01310; cycle 2 cwr=0, csel=000.
- Read latency: req1 read addr=12'h000 with the memory model returning 20'h0ABCD → crd=1 in cycle 1, rvalid1=1 and rdata=0ABCD in cycle 2, rvalid0 stays 0.
- Round robin: req0 and req1 held high with no lock for 6 cycles, from reset → grants alternate 0,1,0,1,0,1.
- Lock burst: req1 with lock1=1 for 3 reads then lock1=0 on the 4th, with req0 high throughout → gnt1 four consecutive cycles, then gnt0; caddr_rd sequence 000,001,040,041.
- Lock starvation limit: lock1 stays 1 indefinitely, req0 high, LOCK_MAX=4 → after 4 gnt1, one idle cycle, then gnt0.
- Illegal sel plus reset: sel0=3'b010 read → gnt0, no crd, rvalid0 with rdata=0, sel_err=1. Then reset=0 → sel_err=0, all strobes 0, next grant goes to requester 0.
